// File: rtl/fifo_mem_responder.sv
// Byte-stream request executor: pops request packets, runs one memory transaction, pushes a response.
// Optional MEM_REQ timeout enabled by defining FIFO_RESP_TIMEOUT_EN.
module fifo_mem_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        CLK,
  input  logic        RESETn,
  output logic        RDEN,
  input  logic        RDEMPTY,
  input  logic [7:0]  RDDATA,
  output logic        WREN,
  input  logic        WRFULL,
  output logic [7:0]  WRDATA,
  output logic        MEM_REQ,
  output logic        MEM_WRITE,
  output logic [1:0]  MEM_SIZE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA,
  input  logic        MEM_ERR,
  output logic        BUSY
);

  typedef enum logic [2:0] {
    S_HDR, S_ADDR, S_WDATA, S_MEM, S_RESP, S_RDATA
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state;
  logic        run;
  logic        pend;
  logic [1:0]  cnt;
  logic [1:0]  n_last;
  logic [7:0]  status;
  logic        write;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        req;
  logic        need;
  logic        hdr_bad;
  logic        misalign;
  logic [7:0]  wr_byte;

  assign need = run & ((state == S_HDR) | (state == S_ADDR) |
                       (state == S_WDATA));
  assign RDEN = need & ~pend & ~RDEMPTY;
  assign WREN = ((state == S_RESP) | (state == S_RDATA)) & ~WRFULL;
  assign WRDATA = wr_byte;

  assign hdr_bad = RDDATA[6] | (|RDDATA[3:0]) | (&RDDATA[5:4]);
  assign misalign = ((size == 2'd1) & addr[0]) |
                    ((size == 2'd2) & (|addr[1:0]));

  assign MEM_REQ   = req;
  assign MEM_WRITE = write;
  assign MEM_SIZE  = size;
  assign MEM_ADDR  = addr;
  assign MEM_WDATA = wdata;
  assign BUSY      = (state != S_HDR);

  // Index of the last data byte for the current transfer size.
  always_comb begin
    n_last = 2'd3;
    unique case (size)
      2'd0:    n_last = 2'd0;
      2'd1:    n_last = 2'd1;
      default: n_last = 2'd3;
    endcase
  end

  // Outgoing byte: status first, then read data LSB first.
  always_comb begin
    wr_byte = 8'h00;
    unique case (1'b1)
      state == S_RESP:  wr_byte = status;
      state == S_RDATA: wr_byte = rdata[{cnt, 3'b000} +: 8];
      default: ;
    endcase
  end

`ifdef FIFO_RESP_TIMEOUT_EN
  logic [31:0] tcnt;
  logic        tmo;

  assign tmo = req & (tcnt == 32'(TIMEOUT_CYCLES - 1));

  // Counts cycles with MEM_REQ high; idle value is zero on MEM entry.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      tcnt <= '0;
    end else if ((state != S_MEM) || !req) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 32'd1;
    end
  end
`endif

  // Packet sequencer: fetch, execute, respond.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state  <= S_HDR;
      run    <= 1'b0;
      pend   <= 1'b0;
      cnt    <= 2'd0;
      status <= 8'h00;
      write  <= 1'b0;
      size   <= 2'd0;
      addr   <= '0;
      wdata  <= '0;
      rdata  <= '0;
      req    <= 1'b0;
    end else begin
      run  <= 1'b1;
      pend <= RDEN;
      unique case (state)
        S_HDR: begin
          if (pend) begin
            cnt   <= 2'd0;
            wdata <= '0;
            if (hdr_bad) begin
              status <= 8'h02;
              state  <= S_RESP;
            end else begin
              write <= RDDATA[7];
              size  <= RDDATA[5:4];
              state <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (pend) begin
            addr[{cnt, 3'b000} +: 8] <= RDDATA;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              cnt   <= 2'd0;
              state <= write ? S_WDATA : S_MEM;
            end
          end
        end
        S_WDATA: begin
          if (pend) begin
            wdata[{cnt, 3'b000} +: 8] <= RDDATA;
            cnt <= cnt + 2'd1;
            if (cnt == n_last) begin
              cnt   <= 2'd0;
              state <= S_MEM;
            end
          end
        end
        S_MEM: begin
          if (!req) begin
            if (misalign) begin
              status <= 8'h01;
              state  <= S_RESP;
            end else begin
              req <= 1'b1;
            end
          end else if (MEM_ACK) begin
            req    <= 1'b0;
            status <= {7'd0, MEM_ERR};
            rdata  <= MEM_RDATA;
            state  <= S_RESP;
          end
`ifdef FIFO_RESP_TIMEOUT_EN
          else if (tmo) begin
            req    <= 1'b0;
            status <= 8'h03;
            state  <= S_RESP;
          end
`endif
        end
        S_RESP: begin
          if (!WRFULL) begin
            cnt   <= 2'd0;
            state <= ((status == 8'h00) && !write) ? S_RDATA : S_HDR;
          end
        end
        S_RDATA: begin
          if (!WRFULL) begin
            cnt <= cnt + 2'd1;
            if (cnt == n_last) begin
              cnt   <= 2'd0;
              state <= S_HDR;
            end
          end
        end
        default: state <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_mem_responder.sv
// Directed bench for fifo_mem_responder: FIFO and memory models plus vector table.
// Timeout checks follow FIFO_RESP_TIMEOUT_EN.
module tb_fifo_mem_responder;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        RDEN;
  logic        RDEMPTY;
  logic [7:0]  RDDATA = 8'h00;
  logic        WREN;
  logic        WRFULL = 1'b0;
  logic [7:0]  WRDATA;
  logic        MEM_REQ;
  logic        MEM_WRITE;
  logic [1:0]  MEM_SIZE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic        MEM_ACK = 1'b0;
  logic [31:0] MEM_RDATA = 32'h0;
  logic        MEM_ERR = 1'b0;
  logic        BUSY;

  fifo_mem_responder #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RESETn(RESETn),
    .RDEN(RDEN), .RDEMPTY(RDEMPTY), .RDDATA(RDDATA),
    .WREN(WREN), .WRFULL(WRFULL), .WRDATA(WRDATA),
    .MEM_REQ(MEM_REQ), .MEM_WRITE(MEM_WRITE), .MEM_SIZE(MEM_SIZE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK),
    .MEM_RDATA(MEM_RDATA), .MEM_ERR(MEM_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // request FIFO model
  logic [7:0] req_mem [0:1023];
  int rq_wp = 0;
  int rq_rp = 0;
  bit gap = 0;
  bit gap_en = 0;
  int rd_viol = 0;
  assign RDEMPTY = gap | (rq_rp == rq_wp);

  always @(posedge CLK) begin
    if (RDEN) begin
      if (RDEMPTY) rd_viol <= rd_viol + 1;
      RDDATA <= req_mem[rq_rp];
      rq_rp <= rq_rp + 1;
    end
  end

  always @(negedge CLK) gap = gap_en && ($urandom_range(0, 2) == 0);

  // response FIFO model
  logic [7:0] resp_mem [0:1023];
  int rs_wp = 0;
  int wr_viol = 0;

  always @(posedge CLK) begin
    if (WREN) begin
      if (WRFULL) wr_viol <= wr_viol + 1;
      resp_mem[rs_wp] <= WRDATA;
      rs_wp <= rs_wp + 1;
    end
  end

  // memory port model
  logic [31:0] rdata_cfg = 32'h0;
  bit err_cfg = 0;
  bit mem_never = 0;
  bit stray = 0;
  int ack_delay = 1;
  int req_cyc = 0;
  int req_len = 0;
  int txn_cnt = 0;
  logic        last_w;
  logic [1:0]  last_s;
  logic [31:0] last_a;
  logic [31:0] last_wd;

  always @(negedge CLK) begin
    MEM_RDATA = rdata_cfg;
    MEM_ERR = err_cfg;
    if (MEM_REQ) begin
      req_cyc = req_cyc + 1;
      MEM_ACK = !mem_never && (req_cyc == ack_delay);
      if (MEM_ACK) begin
        txn_cnt = txn_cnt + 1;
        last_w = MEM_WRITE;
        last_s = MEM_SIZE;
        last_a = MEM_ADDR;
        last_wd = MEM_WDATA;
      end
    end else begin
      if (req_cyc != 0) req_len = req_cyc;
      req_cyc = 0;
      MEM_ACK = stray;
    end
  end

  typedef struct {
    logic [71:0] rq;
    int          nrq;
    logic [31:0] rd;
    bit          er;
    logic [39:0] rs;
    int          nrs;
    bit          xr;
    bit          w;
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] wd;
    bit          st;
  } vec_t;

  function automatic vec_t mk(
    input logic [71:0] rq, input int nrq, input logic [31:0] rd,
    input bit er, input logic [39:0] rs, input int nrs, input bit xr,
    input bit w, input logic [1:0] s, input logic [31:0] a,
    input logic [31:0] wd, input bit st);
    vec_t v;
    v.rq = rq; v.nrq = nrq; v.rd = rd; v.er = er;
    v.rs = rs; v.nrs = nrs; v.xr = xr; v.w = w;
    v.s = s; v.a = a; v.wd = wd; v.st = st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    req_mem[rq_wp] = b;
    rq_wp = rq_wp + 1;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int rs0;
    int tx0;
    int rs1;
    bit done;
    bit stalled;
    logic [7:0] eb;
    rs0 = rs_wp;
    tx0 = txn_cnt;
    rdata_cfg = v.rd;
    err_cfg = v.er;
    for (int i = 0; i < v.nrq; i++) push(v.rq[71-8*i -: 8]);
    done = 0;
    stalled = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge CLK);
      if (v.st && !stalled && (rs_wp - rs0 == 2)) begin
        WRFULL = 1'b1;
        rs1 = rs_wp;
        repeat (10) @(negedge CLK);
        chk({nm, "_stall_hold"}, rs_wp - rs1, 0);
        chk({nm, "_stall_busy"}, BUSY, 1);
        WRFULL = 1'b0;
        stalled = 1;
      end
      if ((rs_wp - rs0 >= v.nrs) && (rq_rp == rq_wp) && !BUSY) done = 1;
    end
    repeat (4) @(negedge CLK);
    chk({nm, "_done"}, done, 1);
    chk({nm, "_nresp"}, rs_wp - rs0, v.nrs);
    for (int i = 0; i < v.nrs; i++) begin
      eb = v.rs[39-8*i -: 8];
      chk($sformatf("%s_b%0d", nm, i), resp_mem[rs0+i], eb);
    end
    chk({nm, "_ntxn"}, txn_cnt - tx0, v.xr);
    if (v.xr) begin
      chk({nm, "_write"}, last_w, v.w);
      chk({nm, "_size"}, last_s, v.s);
      chk({nm, "_addr"}, last_a, v.a);
      chk({nm, "_wdata"}, last_wd, v.wd);
    end
  endtask

  vec_t vt [12];
  vec_t rd_word;
  int rs1;
  int tx1;

  initial begin
    vt[0]  = mk(72'hA0_00_10_00_20_EF_BE_AD_DE, 9, 32'h0, 0,
                40'h00_00_00_00_00, 1, 1, 1, 2'd2, 32'h2000_1000,
                32'hDEAD_BEEF, 0);
    vt[1]  = mk(72'h10_02_00_00_40_00_00_00_00, 5, 32'h1234_ABCD, 0,
                40'h00_CD_AB_00_00, 3, 1, 0, 2'd1, 32'h4000_0002,
                32'h0, 0);
    vt[2]  = mk(72'h20_01_00_00_00_00_00_00_00, 5, 32'h0, 0,
                40'h01_00_00_00_00, 1, 0, 0, 2'd0, 32'h0, 32'h0, 0);
    vt[3]  = mk(72'h30_00_00_00_00_00_00_00_00, 1, 32'h0, 0,
                40'h02_00_00_00_00, 1, 0, 0, 2'd0, 32'h0, 32'h0, 0);
    vt[4]  = mk(72'h20_00_00_00_00_00_00_00_00, 5, 32'h1122_3344, 0,
                40'h00_44_33_22_11, 5, 1, 0, 2'd2, 32'h0, 32'h0, 0);
    vt[5]  = mk(72'h80_03_00_00_00_5A_00_00_00, 6, 32'h0, 1,
                40'h01_00_00_00_00, 1, 1, 1, 2'd0, 32'h3,
                32'h0000_005A, 0);
    vt[6]  = mk(72'h00_05_00_00_00_00_00_00_00, 5, 32'hAABB_CCDD, 0,
                40'h00_DD_00_00_00, 2, 1, 0, 2'd0, 32'h5, 32'h0, 0);
    vt[7]  = mk(72'h90_01_00_00_00_34_12_00_00, 7, 32'h0, 0,
                40'h01_00_00_00_00, 1, 0, 0, 2'd0, 32'h0, 32'h0, 0);
    vt[8]  = mk(72'h40_00_00_00_00_00_00_00_00, 1, 32'h0, 0,
                40'h02_00_00_00_00, 1, 0, 0, 2'd0, 32'h0, 32'h0, 0);
    vt[9]  = mk(72'h90_00_01_00_00_34_12_00_00, 7, 32'h0, 0,
                40'h00_00_00_00_00, 1, 1, 1, 2'd1, 32'h0000_0100,
                32'h0000_1234, 0);
    vt[10] = mk(72'h21_00_00_00_00_00_00_00_00, 1, 32'h0, 0,
                40'h02_00_00_00_00, 1, 0, 0, 2'd0, 32'h0, 32'h0, 0);
    vt[11] = mk(72'h20_08_00_00_00_00_00_00_00, 5, 32'h5566_7788, 0,
                40'h00_88_77_66_55, 5, 1, 0, 2'd2, 32'h8, 32'h0, 1);
    rd_word = mk(72'h20_00_00_00_00_00_00_00_00, 5, 32'h9988_7766, 0,
                 40'h00_66_77_88_99, 5, 1, 0, 2'd2, 32'h0, 32'h0, 0);

    repeat (3) @(negedge CLK);
    chk("rst_rden", RDEN, 0);
    chk("rst_wren", WREN, 0);
    chk("rst_memreq", MEM_REQ, 0);
    chk("rst_busy", BUSY, 0);
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);

    for (int p = 0; p < 2; p++) begin
      gap_en = (p == 1);
      for (int k = 0; k < 12; k++) run_vec(vt[k], $sformatf("p%0d_v%0d", p, k));
    end
    gap_en = 0;

    rs1 = rs_wp;
    tx1 = txn_cnt;
    stray = 1;
    repeat (5) @(negedge CLK);
    stray = 0;
    repeat (3) @(negedge CLK);
    chk("stray_nresp", rs_wp - rs1, 0);
    chk("stray_ntxn", txn_cnt - tx1, 0);
    chk("stray_busy", BUSY, 0);

`ifdef FIFO_RESP_TIMEOUT_EN
    mem_never = 1;
    run_vec(mk(72'h20_00_00_00_00_00_00_00_00, 5, 32'h0, 0,
               40'h03_00_00_00_00, 1, 0, 0, 2'd0, 32'h0, 32'h0, 0),
            "tmo_expire");
    chk("tmo_expire_len", req_len, 16);
    mem_never = 0;
    ack_delay = 16;
    run_vec(rd_word, "tmo_edge_ack");
    chk("tmo_edge_len", req_len, 16);
    ack_delay = 1;
`else
    ack_delay = 40;
    run_vec(rd_word, "slow_ack");
    chk("slow_ack_len", req_len, 40);
    ack_delay = 1;
`endif

    rs1 = rs_wp;
    push(8'hA0); push(8'h00); push(8'h00); push(8'h00);
    push(8'h00); push(8'h11); push(8'h22);
    for (int c = 0; c < 100 && rq_rp != rq_wp; c++) @(negedge CLK);
    repeat (4) @(negedge CLK);
    chk("abort_busy", BUSY, 1);
    RESETn = 1'b0;
    #1;
    chk("abort_rden", RDEN, 0);
    chk("abort_wren", WREN, 0);
    chk("abort_wrdata", WRDATA, 0);
    chk("abort_memreq", MEM_REQ, 0);
    chk("abort_memwrite", MEM_WRITE, 0);
    chk("abort_memsize", MEM_SIZE, 0);
    chk("abort_memaddr", MEM_ADDR, 0);
    chk("abort_memwdata", MEM_WDATA, 0);
    chk("abort_busy0", BUSY, 0);
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (5) @(negedge CLK);
    chk("abort_nresp", rs_wp - rs1, 0);
    run_vec(mk(72'h10_04_00_00_00_00_00_00_00, 5, 32'hCAFE_F00D, 0,
               40'h00_0D_F0_00_00, 3, 1, 0, 2'd1, 32'h4, 32'h0, 0),
            "post_rst");

    chk("rden_when_empty", rd_viol, 0);
    chk("wren_when_full", wr_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
